booth_encoder_seq: RTL and testbench

//  Sequential radix-4 Booth encoder: accepts one signed N-bit multiplier X and streams
//  its N/2 Booth digits, one per handshake, as {Single, Double, Negative}. This is the

---
 rtl/booth_pkg.sv | 33 +++
 rtl/booth_digit_encoder.sv | 13 +
 rtl/booth_encoder_seq.sv | 100 ++++++++++
 tb/tb_booth_encoder_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth digit encoding used by the sequential encoder
// and any future parallel encoder array.
package booth_pkg;

  typedef struct packed {
    logic single;
    logic dbl;
    logic neg;
  } booth_digit_t;

  typedef enum logic {
    IDLE,
    EMIT
  } booth_enc_state_t;

  // Triplet is (x[2i+1], x[2i], x[2i-1]); 111 encodes -0, which the consumer nulls via carry.
  function automatic booth_digit_t booth_encode(input logic [2:0] trip);
    booth_digit_t d;
    unique case (trip)
      3'b000:  d = '{single: 1'b0, dbl: 1'b0, neg: 1'b0};
      3'b001:  d = '{single: 1'b1, dbl: 1'b0, neg: 1'b0};
      3'b010:  d = '{single: 1'b1, dbl: 1'b0, neg: 1'b0};
      3'b011:  d = '{single: 1'b0, dbl: 1'b1, neg: 1'b0};
      3'b100:  d = '{single: 1'b0, dbl: 1'b1, neg: 1'b1};
      3'b101:  d = '{single: 1'b1, dbl: 1'b0, neg: 1'b1};
      3'b110:  d = '{single: 1'b1, dbl: 1'b0, neg: 1'b1};
      3'b111:  d = '{single: 1'b0, dbl: 1'b0, neg: 1'b1};
      default: d = '{single: 1'b0, dbl: 1'b0, neg: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_digit_encoder.sv
// Combinational radix-4 Booth digit encoder: one bit triplet in, one {single, dbl, neg} out.
module booth_digit_encoder
  import booth_pkg::*;
(
  input  logic [2:0]   trip_i,
  output booth_digit_t digit_o
);

  always_comb begin
    digit_o = booth_encode(trip_i);
  end

endmodule

// File: rtl/booth_encoder_seq.sv
// Sequential radix-4 Booth encoder: loads one signed N-bit multiplier and streams its N/2
// digits over a valid/ready handshake. Optional feature macro: BOOTH_ZERO_SKIP_EN.
module booth_encoder_seq
  import booth_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           X,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   Single,
  output logic                   Double,
  output logic                   Negative,
  output logic [$clog2(N/2)-1:0] digit_idx,
  output logic                   last
);

  localparam int unsigned D    = N / 2;
  localparam int unsigned IdxW = $clog2(D);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(D - 1);

  booth_enc_state_t state_q, state_d;
  logic [N:0]       sr_q, sr_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  booth_digit_t digit;
  logic         is_last;
  logic         skip;
  logic         valid_int;
  logic         advance;

  booth_digit_encoder u_digit_enc (
    .trip_i  (sr_q[2:0]),
    .digit_o (digit)
  );

  always_comb begin
    is_last = (idx_q == LastIdx);
`ifdef BOOTH_ZERO_SKIP_EN
    // Zero-magnitude digits (including -0) contribute nothing; the final digit is always shown.
    skip = (state_q == EMIT) && !digit.single && !digit.dbl && !is_last;
`else
    skip = 1'b0;
`endif
    valid_int = (state_q == EMIT) && !skip;
    advance   = (valid_int && out_ready) || skip;
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = {X, 1'b0};
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (advance) begin
          sr_d  = {{2{sr_q[N]}}, sr_q[N:2]};
          idx_d = idx_q + IdxW'(1);
          if (is_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = valid_int;
    Single    = valid_int & digit.single;
    Double    = valid_int & digit.dbl;
    Negative  = valid_int & digit.neg;
    digit_idx = valid_int ? idx_q : '0;
    last      = valid_int & is_last;
  end

endmodule

// File: tb/tb_booth_encoder_seq.sv
// Randomized self-checking bench for booth_encoder_seq against an arithmetic Booth digit model.
// Honours BOOTH_ZERO_SKIP_EN when the bench is built with the same define as the RTL.
module tb_booth_encoder_seq;

  localparam int unsigned N  = 32;
  localparam int unsigned D  = N / 2;
  localparam int unsigned IW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  x_in;
  logic          out_valid;
  logic          out_ready;
  logic          single;
  logic          dbl;
  logic          neg;
  logic [IW-1:0] digit_idx;
  logic          last;

  int n_cmp = 0;
  int n_bad = 0;

  booth_encoder_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Single    (single),
    .Double    (dbl),
    .Negative  (neg),
    .digit_idx (digit_idx),
    .last      (last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Booth digit value: x[2i-1] + x[2i] - 2*x[2i+1], with x[-1] = 0.
  function automatic int ref_digit(input logic [N-1:0] x, input int i);
    int lo;
    lo = (i == 0) ? 0 : int'(x[2*i-1]);
    return lo + int'(x[2*i]) - 2 * int'(x[2*i+1]);
  endfunction

  function automatic bit presented(input logic [N-1:0] x, input int i);
`ifdef BOOTH_ZERO_SKIP_EN
    return (ref_digit(x, i) != 0) || (i == D - 1);
`else
    return 1'b1;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_x(input logic [N-1:0] x);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check_eq("in_ready_before_load", in_ready, 1);
    in_valid = 1'b1;
    x_in     = x;
    tick();
    in_valid = 1'b0;
    x_in     = $urandom;
  endtask

  // Streams one operand and checks every presented digit, the digit sum and the idle gaps.
  task automatic run_op(input logic [N-1:0] x, input int stall_idx, input int stall_len,
                        input bit rand_ready);
    int i, hs, gaps, cyc, stall, d, exp_hs, exp_gaps;
    logic signed [63:0] sum;
    bit done;
    i = 0; hs = 0; gaps = 0; cyc = 0; stall = 0; sum = 0; done = 1'b0;
    exp_hs = 0;
    for (int k = 0; k < int'(D); k++) if (presented(x, k)) exp_hs++;
    exp_gaps = int'(D) - exp_hs;
    send_x(x);
    while (!done && cyc < 300) begin
      cyc++;
      while (i < int'(D) - 1 && !presented(x, i)) i++;
      if (out_valid) begin
        d = ref_digit(x, i);
        check_eq("digit_idx", digit_idx, i);
        check_eq("single", single, (d == 1 || d == -1));
        check_eq("double", dbl, (d == 2 || d == -2));
        check_eq("negative", neg, x[2*i+1]);
        check_eq("last", last, (i == int'(D) - 1));
        check_eq("in_ready_emit", in_ready, 0);
        if (i == stall_idx && stall < stall_len) begin
          out_ready = 1'b0;
          stall++;
        end else if (rand_ready) begin
          out_ready = ($urandom_range(0, 3) != 0);
        end else begin
          out_ready = 1'b1;
        end
        if (out_ready) begin
          d = single ? 1 : (dbl ? 2 : 0);
          if (neg) d = -d;
          sum += 64'(d) * (64'sd1 <<< (2 * i));
          hs++;
          if (last) done = 1'b1;
          i++;
        end
      end else begin
        gaps++;
        check_eq("in_ready_gap", in_ready, 0);
        check_eq("gap_digit_zero", {single, dbl, neg, last}, 0);
      end
      tick();
    end
    out_ready = 1'b1;
    check_eq("op_completed", done, 1);
    check_eq("in_ready_after_last", in_ready, 1);
    check_eq("out_valid_after_last", out_valid, 0);
    check_eq("digit_sum", sum, $signed(x));
    check_eq("handshakes", hs, exp_hs);
    check_eq("idle_gaps", gaps, exp_gaps);
  endtask

  initial begin
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x_in      = '0;
    out_ready = 1'b1;
    #12;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_digit", {single, dbl, neg, last}, 0);
    check_eq("rst_idx", digit_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op(32'd10, -1, 0, 1'b0);
    run_op(32'hFFFF_FFFF, -1, 0, 1'b0);
    run_op(32'h8000_0000, -1, 0, 1'b0);
    run_op(32'h0000_0000, -1, 0, 1'b0);
    run_op(32'h7FFF_FFFF, -1, 0, 1'b0);
    run_op(32'd10, 1, 3, 1'b0);

    // Reset in the middle of an operand discards the rest of it.
    send_x(32'd10);
    w = 0;
    while (!(out_valid && digit_idx == IW'(5)) && w < 40) begin
      tick();
      w++;
    end
`ifndef BOOTH_ZERO_SKIP_EN
    check_eq("reached_idx5", digit_idx, 5);
`endif
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_idx", digit_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(32'd3, -1, 0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      run_op($urandom, int'($urandom_range(0, D - 1)), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
